// File: rtl/rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// rgb_pwm_driver
//
// Output stage for the RGB LED colour sequencers. Per-channel target
// brightness values arrive over a valid/ready handshake, are parked in a
// pending buffer and transferred to the active targets only at PWM period
// boundaries. The applied duty of each channel slews toward its target by at
// most SLEW_STEP per period. The LED pins are driven active-low.
//
// Parameters
//   PWM_BITS  : duty / step-counter width; one period is 2**PWM_BITS steps
//   PRESCALE  : clock cycles per PWM step (>= 1)
//   SLEW_STEP : max duty change per period, 0 = jump straight to target
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   in_valid     in   in_r/in_g/in_b triple is valid
//   in_ready     out  a triple can be accepted (no pending triple)
//   in_r/g/b     in   target duties
//   period_start out  high during the first cycle of each PWM period
//   busy         out  pending triple exists or any applied duty != target
//   RGB_R/G/B    out  LED drive, active-low (0 = lit)
// -----------------------------------------------------------------------------
module rgb_pwm_driver #(
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 47,
  parameter int SLEW_STEP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] in_r,
  input  logic [PWM_BITS-1:0] in_g,
  input  logic [PWM_BITS-1:0] in_b,
  output logic                period_start,
  output logic                busy,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  // A prescaler of 1 still needs a 1-bit register; it just stays at zero.
  localparam int                  PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};

  // A step larger than the full duty range behaves like the full range, so
  // clamp it to something representable in PWM_BITS.
  localparam int STEP_CLAMP = (SLEW_STEP > ((2 ** PWM_BITS) - 1)) ?
                              ((2 ** PWM_BITS) - 1) : SLEW_STEP;
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP_CLAMP);

  // Move duty one bounded step toward target. The gap is measured in
  // PWM_BITS+1 bits so the subtraction can never wrap; the add/subtract is
  // only taken when the gap exceeds the step, so it can neither overshoot
  // the target nor leave the 0..2**PWM_BITS-1 range.
  function automatic logic [PWM_BITS-1:0] slew_toward(
    input logic [PWM_BITS-1:0] duty,
    input logic [PWM_BITS-1:0] target
  );
    logic [PWM_BITS:0]   duty_x;
    logic [PWM_BITS:0]   target_x;
    logic [PWM_BITS:0]   step_x;
    logic [PWM_BITS:0]   gap;
    logic [PWM_BITS-1:0] res;
    duty_x   = {1'b0, duty};
    target_x = {1'b0, target};
    step_x   = {1'b0, STEP_N};
    gap      = {(PWM_BITS+1){1'b0}};
    res      = duty;
    if (STEP_N == {PWM_BITS{1'b0}}) begin
      res = target;
    end else if (duty_x < target_x) begin
      gap = target_x - duty_x;
      if (gap > step_x) begin
        res = duty + STEP_N;
      end else begin
        res = target;
      end
    end else if (duty_x > target_x) begin
      gap = duty_x - target_x;
      if (gap > step_x) begin
        res = duty - STEP_N;
      end else begin
        res = target;
      end
    end else begin
      res = duty;
    end
    return res;
  endfunction

  // Channel index 0 = red, 1 = green, 2 = blue throughout.
  logic [PRESC_W-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0]      cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [2:0][PWM_BITS-1:0] pend_q, pend_d;
  logic [2:0][PWM_BITS-1:0] target_q, target_d;
  logic [2:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [2:0]               rgb_q, rgb_d;

  logic [2:0][PWM_BITS-1:0] in_s;
  logic                     boundary_s;
  logic                     accept_s;

  assign in_s       = {in_b, in_g, in_r};
  assign boundary_s = (presc_q == PRESC_MAX) && (cnt_q == CNT_MAX);
  assign accept_s   = in_valid && !pending_q;

  // Step prescaler and PWM step counter.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = {PRESC_W{1'b0}};
      cnt_d   = cnt_q + PWM_BITS'(1);
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Boundary slew / target transfer and handshake capture. Acceptance needs
  // pending clear, so a boundary transfer and a capture never compete for
  // the pending flag in the same cycle; a capture on the boundary cycle
  // itself simply waits for the following boundary.
  always_comb begin
    pending_d = pending_q;
    pend_d    = pend_q;
    target_d  = target_q;
    duty_d    = duty_q;
    if (boundary_s) begin
      for (int i = 0; i < 3; i++) begin
        duty_d[i] = slew_toward(duty_q[i], target_q[i]);
      end
      if (pending_q) begin
        target_d  = pend_q;
        pending_d = 1'b0;
      end else begin
        target_d  = target_q;
      end
    end else begin
      duty_d = duty_q;
    end
    if (accept_s) begin
      pend_d    = in_s;
      pending_d = 1'b1;
    end else begin
      pend_d    = pend_q;
    end
  end

  // PWM compare; the pins are registered so they lag cnt by one cycle.
  always_comb begin
    rgb_d = 3'b111;
    for (int i = 0; i < 3; i++) begin
      rgb_d[i] = ~(cnt_q < duty_q[i]);
    end
  end

  // State registers; reset leaves the LEDs dark and drops any pending triple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= {PRESC_W{1'b0}};
      cnt_q     <= {PWM_BITS{1'b0}};
      pending_q <= 1'b0;
      pend_q    <= {(3*PWM_BITS){1'b0}};
      target_q  <= {(3*PWM_BITS){1'b0}};
      duty_q    <= {(3*PWM_BITS){1'b0}};
      rgb_q     <= 3'b111;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      target_q  <= target_d;
      duty_q    <= duty_d;
      rgb_q     <= rgb_d;
    end
  end

  assign in_ready     = ~pending_q;
  assign period_start = (presc_q == {PRESC_W{1'b0}}) && (cnt_q == {PWM_BITS{1'b0}});
  assign busy         = pending_q || (duty_q != target_q);
  assign RGB_R        = rgb_q[0];
  assign RGB_G        = rgb_q[1];
  assign RGB_B        = rgb_q[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_driver
//
// Three instances (SLEW_STEP 0, 1, 4) share one clock, reset and input
// stream, PWM_BITS=4, PRESCALE=2 (32-cycle period). A period-level model
// tracks pending/target/duty; at every period start the expected lit-cycle
// counts for that period are pushed to a queue and popped when the pin
// observation window (cycles 1..32 of the period, pins lag cnt by one) closes.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_driver;

  localparam int PB  = 4;
  localparam int PS  = 2;
  localparam int PER = PS * (2 ** PB);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [PB-1:0] in_r, in_g, in_b;
  logic [2:0]    rdy, bsy, pst, pin_r, pin_g, pin_b;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PWM_BITS(PB), .PRESCALE(PS), .SLEW_STEP(0)) dut_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .period_start(pst[0]), .busy(bsy[0]),
    .RGB_R(pin_r[0]), .RGB_G(pin_g[0]), .RGB_B(pin_b[0]));

  rgb_pwm_driver #(.PWM_BITS(PB), .PRESCALE(PS), .SLEW_STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .period_start(pst[1]), .busy(bsy[1]),
    .RGB_R(pin_r[1]), .RGB_G(pin_g[1]), .RGB_B(pin_b[1]));

  rgb_pwm_driver #(.PWM_BITS(PB), .PRESCALE(PS), .SLEW_STEP(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .period_start(pst[2]), .busy(bsy[2]),
    .RGB_R(pin_r[2]), .RGB_G(pin_g[2]), .RGB_B(pin_b[2]));

  typedef struct {
    int at;
    int r;
    int g;
    int b;
  } stim_t;

  stim_t stim_q[$];
  int    exp_q[$];

  int errors = 0;
  int checks = 0;

  int slew_of [3] = '{0, 1, 4};
  int m_cycle;
  bit m_pending;
  int m_pend [3];
  int m_tgt  [3];
  int m_duty [3][3];
  int lit    [3][3];
  bit win_open;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_cycle);
    end
  endtask

  function automatic int model_slew(input int d, input int t, input int s);
    if (s == 0) return t;
    if (d < t) return ((t - d) > s) ? d + s : t;
    if (d > t) return ((d - t) > s) ? d - s : t;
    return d;
  endfunction

  function automatic int pin_of(input int k, input int c);
    case (c)
      0:       return int'(pin_r[k]);
      1:       return int'(pin_g[k]);
      default: return int'(pin_b[k]);
    endcase
  endfunction

  task automatic model_reset();
    m_cycle   = 0;
    m_pending = 1'b0;
    win_open  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      m_pend[c] = 0;
      m_tgt[c]  = 0;
      for (int k = 0; k < 3; k++) begin
        m_duty[k][c] = 0;
        lit[k][c]    = 0;
      end
    end
  endtask

  // Model of one clock edge, using the values the DUTs saw before the edge.
  task automatic model_edge();
    bit boundary;
    bit acc;
    boundary = ((m_cycle % PER) == (PER - 1));
    acc      = in_valid && !m_pending;
    if (boundary) begin
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 3; c++)
          m_duty[k][c] = model_slew(m_duty[k][c], m_tgt[c], slew_of[k]);
      if (m_pending) begin
        for (int c = 0; c < 3; c++) m_tgt[c] = m_pend[c];
        m_pending = 1'b0;
      end
    end
    if (acc) begin
      m_pend[0] = int'(in_r);
      m_pend[1] = int'(in_g);
      m_pend[2] = int'(in_b);
      m_pending = 1'b1;
      void'(stim_q.pop_front());
    end
    m_cycle++;
  endtask

  task automatic sample();
    bit exp_busy;
    for (int k = 0; k < 3; k++) begin
      exp_busy = m_pending;
      for (int c = 0; c < 3; c++)
        if (m_duty[k][c] != m_tgt[c]) exp_busy = 1'b1;
      check_eq($sformatf("in_ready[s%0d]", slew_of[k]), int'(rdy[k]), int'(!m_pending));
      check_eq($sformatf("busy[s%0d]", slew_of[k]), int'(bsy[k]), int'(exp_busy));
      check_eq($sformatf("period_start[s%0d]", slew_of[k]), int'(pst[k]),
               int'((m_cycle % PER) == 0));
    end
    if (win_open)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 3; c++)
          if (pin_of(k, c) == 0) lit[k][c]++;
    if ((m_cycle % PER) == 0) begin
      if (win_open) begin
        for (int k = 0; k < 3; k++)
          for (int c = 0; c < 3; c++) begin
            if (exp_q.size() == 0) begin
              check_eq("scoreboard_empty", 1, 0);
            end else begin
              check_eq($sformatf("lit[s%0d][ch%0d]", slew_of[k], c), lit[k][c],
                       exp_q.pop_front());
            end
          end
      end
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 3; c++) begin
          exp_q.push_back(m_duty[k][c] * PS);
          lit[k][c] = 0;
        end
      win_open = 1'b1;
    end
  endtask

  task automatic drive();
    if (stim_q.size() > 0 && m_cycle >= stim_q[0].at) begin
      in_valid = 1'b1;
      in_r     = PB'(stim_q[0].r);
      in_g     = PB'(stim_q[0].g);
      in_b     = PB'(stim_q[0].b);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    sample();
    drive();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_r     = '0;
    in_g     = '0;
    in_b     = '0;
    model_reset();
    stim_q.push_back('{3, 8, 0, 15});
    stim_q.push_back('{400, 4, 0, 0});
    stim_q.push_back('{700, 15, 0, 0});
    stim_q.push_back('{700, 0, 15, 0});
    stim_q.push_back('{1100, 0, 0, 0});
    stim_q.push_back('{1500, 15, 15, 15});
    stim_q.push_back('{1600, 5, 5, 5});

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_pins", int'({pin_r[k], pin_g[k], pin_b[k]}), 7);
      check_eq("rst_ready", int'(rdy[k]), 1);
      check_eq("rst_busy", int'(bsy[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    sample();
    drive();

    while (m_cycle < 1605) tick();

    // Mid-period asynchronous reset while the SLEW_STEP=0 red channel is lit
    // and a (5,5,5) triple sits unapplied in pending.
    check_eq("pre_rst_lit", int'(pin_r[0]), 0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("async_rst_pins", int'({pin_r[k], pin_g[k], pin_b[k]}), 7);
      check_eq("async_rst_ready", int'(rdy[k]), 1);
      check_eq("async_rst_busy", int'(bsy[k]), 0);
      check_eq("async_rst_pstart", int'(pst[k]), 1);
    end
    stim_q.delete();
    exp_q.delete();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    sample();
    drive();
    repeat (100) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
